// File: rtl/fetch_sequencer_if.sv
// Fetch-side bus: instruction memory port, decoder handshake and redirect request.
// The sequencer connects through the master modport.
interface fetch_sequencer_if #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 8
);
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_data;
  logic [INSTR_W-1:0] instr;
  logic [ADDR_W-1:0]  instr_pc;
  logic               instr_valid;
  logic               instr_ready;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_addr;

  modport master (
    output imem_addr,
    input  imem_data,
    output instr,
    output instr_pc,
    output instr_valid,
    input  instr_ready,
    input  redirect_valid,
    input  redirect_addr
  );

  modport slave (
    input  imem_addr,
    output imem_data,
    input  instr,
    input  instr_pc,
    input  instr_valid,
    output instr_ready,
    output redirect_valid,
    output redirect_addr
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, reads a combinational memory and feeds a one-entry
// valid/ready stage. Optional halt-opcode termination is enabled by FETCH_HALT_DETECT_EN.
module fetch_sequencer #(
  parameter int                 ADDR_W      = 8,
  parameter int                 INSTR_W     = 8,
  parameter int                 PROG_LEN    = 11,
  parameter logic [INSTR_W-1:0] HALT_OPCODE = 8'hFF
) (
  input  logic                clk,
  input  logic                clear,
  input  logic                i_start,
  output logic                o_busy,
  output logic                o_done,
  fetch_sequencer_if.master   bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DONE  = 2'd2
  } state_t;

`ifdef FETCH_HALT_DETECT_EN
  localparam logic HALT_EN = 1'b1;
`else
  localparam logic HALT_EN = 1'b0;
`endif

  localparam logic [ADDR_W:0] LP_PROG_LEN = (ADDR_W+1)'(PROG_LEN);

  state_t             r_state;
  logic [ADDR_W-1:0]  r_pc;
  logic [INSTR_W-1:0] r_instr;
  logic [ADDR_W-1:0]  r_instr_pc;
  logic               r_valid;
  logic               r_halt;
  logic               r_busy;
  logic               r_done;

  state_t             w_state_nxt;
  logic [ADDR_W-1:0]  w_pc_nxt;
  logic [INSTR_W-1:0] w_instr_nxt;
  logic [ADDR_W-1:0]  w_instr_pc_nxt;
  logic               w_valid_nxt;
  logic               w_halt_nxt;
  logic               w_in_range;
  logic               w_accept;
  logic               w_load;

  assign w_in_range = ({1'b0, r_pc} < LP_PROG_LEN);
  assign w_accept   = r_valid & bus.instr_ready;
  // A pending halt word blocks further loads until it drains or is redirected away.
  assign w_load     = (r_state == S_FETCH) & ~bus.redirect_valid & w_in_range & ~r_halt
                      & (~r_valid | bus.instr_ready);

  // Next-state and datapath selection for the fetch FSM.
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_instr_nxt    = r_instr;
    w_instr_pc_nxt = r_instr_pc;
    w_valid_nxt    = r_valid;
    w_halt_nxt     = r_halt;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (i_start) begin
          w_pc_nxt    = {ADDR_W{1'b0}};
          w_valid_nxt = 1'b0;
          w_halt_nxt  = 1'b0;
          w_state_nxt = S_FETCH;
        end else begin
          w_state_nxt = r_state;
        end
      end
      S_FETCH: begin
        if (bus.redirect_valid) begin
          w_pc_nxt    = bus.redirect_addr;
          w_valid_nxt = 1'b0;
          w_halt_nxt  = 1'b0;
        end else if (w_load) begin
          w_instr_nxt    = bus.imem_data;
          w_instr_pc_nxt = r_pc;
          w_valid_nxt    = 1'b1;
          w_pc_nxt       = r_pc + {{(ADDR_W-1){1'b0}}, 1'b1};
          if (HALT_EN && (bus.imem_data == HALT_OPCODE)) begin
            w_halt_nxt = 1'b1;
          end else begin
            w_halt_nxt = 1'b0;
          end
        end else if (!w_in_range || r_halt) begin
          // End of program: leave only once the last presented word is gone.
          if (w_accept || !r_valid) begin
            w_valid_nxt = 1'b0;
            w_halt_nxt  = 1'b0;
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_FETCH;
          end
        end else begin
          w_state_nxt = S_FETCH;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_valid_nxt = 1'b0;
        w_halt_nxt  = 1'b0;
      end
    endcase
  end

  // State, PC, output stage and status flags.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      r_state    <= S_IDLE;
      r_pc       <= {ADDR_W{1'b0}};
      r_instr    <= {INSTR_W{1'b0}};
      r_instr_pc <= {ADDR_W{1'b0}};
      r_valid    <= 1'b0;
      r_halt     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_instr    <= w_instr_nxt;
      r_instr_pc <= w_instr_pc_nxt;
      r_valid    <= w_valid_nxt;
      r_halt     <= w_halt_nxt;
      r_busy     <= (w_state_nxt == S_FETCH);
      r_done     <= (w_state_nxt == S_DONE);
    end
  end

  assign bus.imem_addr   = r_pc;
  assign bus.instr       = r_instr;
  assign bus.instr_pc    = r_instr_pc;
  assign bus.instr_valid = r_valid;
  assign o_busy          = r_busy;
  assign o_done          = r_done;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: streaming, stall, redirect, reset, ignored inputs, halt.
module tb_fetch_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic clear;
  logic start;
  logic busy;
  logic done;
  logic [7:0] mem [0:255];
  int tests = 0;
  int fails = 0;

  fetch_sequencer_if #(.ADDR_W(8), .INSTR_W(8)) bus ();

  assign bus.imem_data = mem[bus.imem_addr];

  fetch_sequencer dut (
    .clk     (clk),
    .clear   (clear),
    .i_start (start),
    .o_busy  (busy),
    .o_done  (done),
    .bus     (bus)
  );

  task automatic start_fetch();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (done !== 1'b1) begin
      fails++;
      $display("FAIL %s_done: done=%0b required 1 after %0d cycles", tag, done, n);
    end
  endtask

  task automatic test_reset();
    clear = 1'b0;
    #12;
    tests++;
    if (bus.instr_valid !== 1'b0 || bus.instr !== 8'h00 || bus.instr_pc !== 8'h00 ||
        bus.imem_addr !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL reset: valid=%0b instr=%0h pc=%0h addr=%0h busy=%0b done=%0b required all 0",
               bus.instr_valid, bus.instr, bus.instr_pc, bus.imem_addr, busy, done);
    end
    @(negedge clk);
    clear = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_addr  = 8'd7;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    tests++;
    if (busy !== 1'b0 || bus.imem_addr !== 8'h00 || bus.instr_valid !== 1'b0) begin
      fails++;
      $display("FAIL idle_redirect: busy=%0b addr=%0h valid=%0b required 0 00 0",
               busy, bus.imem_addr, bus.instr_valid);
    end
  endtask

  task automatic test_stream();
    bus.instr_ready = 1'b1;
    start_fetch();
    tests++;
    if (busy !== 1'b1 || bus.instr_valid !== 1'b0) begin
      fails++;
      $display("FAIL stream_enter: busy=%0b valid=%0b required 1 0", busy, bus.instr_valid);
    end
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      tests++;
      if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 8'(i) || bus.instr !== 8'(8'hA0 + i)) begin
        fails++;
        $display("FAIL stream_word%0d: valid=%0b pc=%0h instr=%0h required 1 %0h %0h",
                 i, bus.instr_valid, bus.instr_pc, bus.instr, 8'(i), 8'(8'hA0 + i));
      end
    end
    @(negedge clk);
    tests++;
    if (done !== 1'b1 || busy !== 1'b0 || bus.instr_valid !== 1'b0) begin
      fails++;
      $display("FAIL stream_end: done=%0b busy=%0b valid=%0b required 1 0 0",
               done, busy, bus.instr_valid);
    end
  endtask

  task automatic test_stall();
    bus.instr_ready = 1'b1;
    start_fetch();
    repeat (3) @(negedge clk);
    bus.instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++;
      if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 8'd2 || bus.instr !== 8'hA2 ||
          bus.imem_addr !== 8'd3) begin
        fails++;
        $display("FAIL stall_hold%0d: valid=%0b pc=%0h instr=%0h addr=%0h required 1 02 a2 03",
                 i, bus.instr_valid, bus.instr_pc, bus.instr, bus.imem_addr);
      end
    end
    bus.instr_ready = 1'b1;
    @(negedge clk);
    tests++;
    if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 8'd3 || bus.instr !== 8'hA3) begin
      fails++;
      $display("FAIL stall_resume: valid=%0b pc=%0h instr=%0h required 1 03 a3",
               bus.instr_valid, bus.instr_pc, bus.instr);
    end
    wait_done("stall");
  endtask

  task automatic test_redirect();
    bus.instr_ready = 1'b1;
    start_fetch();
    repeat (5) @(negedge clk);
    bus.redirect_valid = 1'b1;
    bus.redirect_addr  = 8'd8;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    tests++;
    if (bus.instr_valid !== 1'b0 || bus.imem_addr !== 8'd8) begin
      fails++;
      $display("FAIL redirect_flush: valid=%0b addr=%0h required 0 08", bus.instr_valid, bus.imem_addr);
    end
    @(negedge clk);
    tests++;
    if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 8'd8 || bus.instr !== 8'hA8) begin
      fails++;
      $display("FAIL redirect_target: valid=%0b pc=%0h instr=%0h required 1 08 a8",
               bus.instr_valid, bus.instr_pc, bus.instr);
    end
    wait_done("redirect");
  endtask

  task automatic test_redirect_end();
    bus.instr_ready = 1'b1;
    start_fetch();
    @(negedge clk);
    bus.redirect_valid = 1'b1;
    bus.redirect_addr  = 8'd200;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    tests++;
    if (bus.instr_valid !== 1'b0 || busy !== 1'b1 || bus.imem_addr !== 8'd200) begin
      fails++;
      $display("FAIL redir_oob_flush: valid=%0b busy=%0b addr=%0h required 0 1 c8",
               bus.instr_valid, busy, bus.imem_addr);
    end
    @(negedge clk);
    tests++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL redir_oob_done: done=%0b busy=%0b required 1 0", done, busy);
    end
  endtask

  task automatic test_clear();
    bus.instr_ready = 1'b1;
    start_fetch();
    repeat (6) @(negedge clk);
    tests++;
    if (bus.instr_pc !== 8'd5) begin
      fails++;
      $display("FAIL clear_pre: pc=%0h required 05", bus.instr_pc);
    end
    #2 clear = 1'b0;
    #1;
    tests++;
    if (bus.instr_valid !== 1'b0 || bus.instr !== 8'h00 || bus.instr_pc !== 8'h00 ||
        bus.imem_addr !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL clear_async: valid=%0b instr=%0h pc=%0h addr=%0h busy=%0b done=%0b required all 0",
               bus.instr_valid, bus.instr, bus.instr_pc, bus.imem_addr, busy, done);
    end
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || bus.instr_valid !== 1'b0) begin
      fails++;
      $display("FAIL clear_idle: busy=%0b valid=%0b required 0 0", busy, bus.instr_valid);
    end
    start_fetch();
    @(negedge clk);
    tests++;
    if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 8'd0 || bus.instr !== 8'hA0) begin
      fails++;
      $display("FAIL clear_restart: valid=%0b pc=%0h instr=%0h required 1 00 a0",
               bus.instr_valid, bus.instr_pc, bus.instr);
    end
    wait_done("clear");
  endtask

  task automatic test_ignored();
    bus.instr_ready = 1'b1;
    @(negedge clk);
    bus.redirect_valid = 1'b1;
    bus.redirect_addr  = 8'd3;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    tests++;
    if (done !== 1'b1 || busy !== 1'b0 || bus.imem_addr !== 8'd11) begin
      fails++;
      $display("FAIL done_redirect: done=%0b busy=%0b addr=%0h required 1 0 0b", done, busy, bus.imem_addr);
    end
    start_fetch();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    tests++;
    if (bus.instr_pc !== 8'd1 || bus.instr !== 8'hA1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL fetch_start: pc=%0h instr=%0h busy=%0b required 01 a1 1", bus.instr_pc, bus.instr, busy);
    end
    @(negedge clk);
    tests++;
    if (bus.instr_pc !== 8'd2) begin
      fails++;
      $display("FAIL fetch_start_next: pc=%0h required 02", bus.instr_pc);
    end
    wait_done("ignored");
  endtask

`ifdef FETCH_HALT_DETECT_EN
  task automatic test_halt();
    mem[3] = 8'hFF;
    bus.instr_ready = 1'b1;
    start_fetch();
    repeat (4) @(negedge clk);
    tests++;
    if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 8'd3 || bus.instr !== 8'hFF) begin
      fails++;
      $display("FAIL halt_word: valid=%0b pc=%0h instr=%0h required 1 03 ff",
               bus.instr_valid, bus.instr_pc, bus.instr);
    end
    @(negedge clk);
    tests++;
    if (done !== 1'b1 || bus.instr_valid !== 1'b0) begin
      fails++;
      $display("FAIL halt_done: done=%0b valid=%0b required 1 0", done, bus.instr_valid);
    end
    mem[3] = 8'hA3;
  endtask
`endif

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = (i < 11) ? 8'(8'hA0 + i) : 8'h00;
    end
    start              = 1'b0;
    bus.instr_ready    = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_addr  = 8'h00;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_redirect_end();
    test_clear();
    test_ignored();
`ifdef FETCH_HALT_DETECT_EN
    test_halt();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Instruction-fetch controller for the 8-bit, 8-bit-addressed combinational instruction memory.
- Owns the program counter (PC), drives the memory address, and registers each returned instruction into a one-entry output stage.
- The stage has a valid/ready handshake toward the decoder.
- Handles start, branch/jump redirect, back-pressure and end-of-program, and sequences the memory on behalf of the core.

Parameters:
- ADDR_W, 8, width of PC and memory address.
- INSTR_W, 8, instruction width.
- PROG_LEN, 11, number of valid instruction words; fetch ends after address PROG_LEN-1.
- HALT_OPCODE, 8'hFF, instruction value treated as halt (used only with the optional feature).

Ports:
- clk  input  1  rising-edge clock
- clear  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse that begins fetch at address 0; honoured only in IDLE or DONE
- imem_addr  output  ADDR_W  address to instruction memory; equals internal PC
- imem_data  input  INSTR_W  combinational read data from instruction memory
- instr  output  INSTR_W  registered instruction to decoder
- instr_pc  output  ADDR_W  address the current instr was fetched from
- instr_valid  output  1  instr/instr_pc hold a valid word
- instr_ready  input  1  decoder accepts instr this cycle
- redirect_valid  input  1  branch/jump taken; flush and refetch
- redirect_addr  input  ADDR_W  redirect target
- busy  output  1  high in FETCH
- done  output  1  high in DONE

Behaviour:
- Reset (clear=0, asynchronous): state=IDLE, PC=0, instr=0, instr_pc=0, instr_valid=0, busy=0, done=0.
- States: IDLE, FETCH, DONE. DONE behaves as IDLE apart from done=1.
- imem_addr = PC at all times; memory is combinational, so data is captured the same cycle.
- "accept" = instr_valid & instr_ready. "load" = in FETCH, no redirect, PC<PROG_LEN, and (!instr_valid | instr_ready).

IDLE/DONE:
- On start: PC<=0, instr_valid<=0, go to FETCH.
- Otherwise hold all state.
- redirect_valid is ignored.

FETCH, priority order:
1. redirect_valid=1: PC<=redirect_addr, instr_valid<=0 (the pending word is flushed even if instr_ready=1, and the decoder must not consume it). Stay in FETCH.
   - A redirect_addr >= PROG_LEN ends the program on the next cycle via rule 3.
2. load: instr<=imem_data, instr_pc<=PC, instr_valid<=1, PC<=PC+1.
3. PC>=PROG_LEN and no load:
   - accept this cycle, or instr_valid=0 → instr_valid<=0, go to DONE.
   - otherwise hold, waiting for the decoder to drain the last word.
4. Otherwise (stall: instr_valid=1 & !instr_ready): hold PC, instr, instr_pc and instr_valid stable.

Timing and boundaries:
- First instruction is valid 1 cycle after start.
- Throughput is 1 instruction/cycle with instr_ready held high.
- PC is ADDR_W bits; the increment wraps modulo 2^ADDR_W. Wrap is unreachable when PROG_LEN<2^ADDR_W.
- start while in FETCH: ignored.
- Reset mid-fetch: immediate return to reset values; no partial word is presented.
- busy = (state==FETCH); done = (state==DONE). Both are registered-state decodes.

Optional Feature:
- Macro: FETCH_HALT_DETECT_EN.
- Defined:
  - When a load captures imem_data==HALT_OPCODE, the word is still presented normally.
  - PC stops advancing; no further loads occur.
  - Once that word is accepted, go to DONE.
  - A redirect before acceptance cancels the halt.
- Undefined: HALT_OPCODE is ignored; termination is by PROG_LEN only.

Test Plan:
- Memory preloaded with words 0..10, PROG_LEN=11, instr_ready=1, pulse start → instr_pc 0..10 on 11 consecutive cycles with matching instr; done=1 the cycle after address 10 is accepted.
- instr_ready=0 for 3 cycles while instr_pc=2 → instr, instr_pc=2 and instr_valid held stable; PC held at 3; resumes at 3 after release.
- redirect_valid=1, redirect_addr=8 while instr_pc=4 is valid → next valid word has instr_pc=8; address 4 is never accepted.
- clear low for one cycle mid-fetch at instr_pc=5 → all outputs 0, state IDLE; a new start restarts at address 0.
- start pulsed during FETCH and redirect during IDLE → both ignored; sequence unchanged.
- FETCH_HALT_DETECT_EN defined, HALT_OPCODE at address 3 → addresses 0..3 delivered, no address 4, done=1 after accepting 3.
